// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG health-test and buffering slice:
// default sizing constants, the raw word type and a popcount helper.
package trng_pkg;

    localparam int FIFO_DEPTH         = 4;
    localparam int RCT_CUTOFF_DEFAULT = 3;
    localparam int APT_WORDS_DEFAULT  = 16;
    localparam int APT_LO_DEFAULT     = 200;
    localparam int APT_HI_DEFAULT     = 312;

    typedef logic [31:0] trng_word_t;

    // Number of set bits in a raw word (0..32).
    function automatic logic [5:0] popcount32(input trng_word_t w);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + 6'(w[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/trng_fifo.sv
// Word FIFO for accepted random words. Pointers wrap modulo DEPTH and the
// level counter carries one extra bit so full and empty are distinguishable.
// Flush has priority over push and pop.
module trng_fifo
    import trng_pkg::*;
#(
    parameter  int DEPTH = FIFO_DEPTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  trng_word_t    i_wdata,
    output trng_word_t    o_rdata,
    output logic          o_valid,
    output logic [LW-1:0] o_level
);

    trng_word_t    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;

    // Storage, pointers and occupancy; a simultaneous push and pop keeps the
    // level and advances both pointers, which is also legal when full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (i_push && !i_pop) begin
                r_level <= r_level + 1'b1;
            end else if (i_pop && !i_push) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_valid = (r_level != '0);
    assign o_level = r_level;

endmodule

// File: rtl/trng_health_fifo.sv
// TRNG post-processing stage: runs repetition-count and adaptive-proportion
// health tests on every raw word that arrives, buffers healthy words in a
// small FIFO and raises an interrupt on threshold, overflow or test failure.
module trng_health_fifo
    import trng_pkg::*;
#(
    parameter  int DEPTH      = FIFO_DEPTH,
    parameter  int RCT_CUTOFF = RCT_CUTOFF_DEFAULT,
    parameter  int APT_WORDS  = APT_WORDS_DEFAULT,
    parameter  int APT_LO     = APT_LO_DEFAULT,
    parameter  int APT_HI     = APT_HI_DEFAULT,
    localparam int LW         = $clog2(DEPTH) + 1,
    localparam int RW         = $clog2(RCT_CUTOFF + 1),
    localparam int WW         = (APT_WORDS > 1) ? $clog2(APT_WORDS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          clear,
    input  logic          in_valid,
    input  logic [31:0]   in_data,
    output logic          in_req,
    input  logic          out_pop,
    output logic [31:0]   out_data,
    output logic          out_valid,
    output logic [LW-1:0] level,
    input  logic [LW-1:0] irq_thresh,
    output logic          overflow,
    output logic          rct_fail,
    output logic          apt_fail,
    output logic          irq
);

    logic          r_overflow;
    logic          r_rct_fail;
    logic          r_apt_fail;
    logic          r_run;
    logic          r_prev_valid;
    trng_word_t    r_prev;
    logic [RW-1:0] r_rep;
    logic [9:0]    r_acc;
    logic [WW-1:0] r_win;

    logic          w_fail;
    logic          w_arrival;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_flush;
    logic [5:0]    w_popcnt;
    logic [RW-1:0] w_rep_next;
    logic          w_rct_trip;
    logic [9:0]    w_apt_total;
    logic          w_win_last;
    logic          w_apt_trip;
    logic [LW-1:0] w_level;
    logic          w_valid;
    trng_word_t    w_rdata;

    assign w_fail      = r_rct_fail | r_apt_fail;
    assign w_arrival   = in_valid & en & ~clear;
    assign w_full      = (w_level == LW'(DEPTH));
    assign w_push      = w_arrival & ~w_fail & (~w_full | out_pop);
    assign w_pop       = out_pop & w_valid;
    assign w_popcnt    = popcount32(in_data);
    assign w_apt_total = r_acc + {4'd0, w_popcnt};
    assign w_win_last  = (r_win == WW'(APT_WORDS - 1));
    assign w_rct_trip  = w_arrival & (w_rep_next == RW'(RCT_CUTOFF));
    assign w_apt_trip  = w_arrival & w_win_last &
                         ((w_apt_total < 10'(APT_LO)) | (w_apt_total > 10'(APT_HI)));
    assign w_flush     = clear | w_rct_trip | w_apt_trip;

    // Next repetition count for the arriving word, saturating at the cutoff.
    always_comb begin
        w_rep_next = r_rep;
        if (!r_prev_valid || (in_data != r_prev)) begin
            w_rep_next = RW'(1);
        end else if (r_rep < RW'(RCT_CUTOFF)) begin
            w_rep_next = r_rep + 1'b1;
        end
    end

    // Sticky overflow and health-failure flags, cleared only by clear or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
            r_rct_fail <= 1'b0;
            r_apt_fail <= 1'b0;
        end else if (clear) begin
            r_overflow <= 1'b0;
            r_rct_fail <= 1'b0;
            r_apt_fail <= 1'b0;
        end else if (w_arrival) begin
            if (!w_fail && w_full && !out_pop) begin
                r_overflow <= 1'b1;
            end
            if (w_rct_trip) begin
                r_rct_fail <= 1'b1;
            end
            if (w_apt_trip) begin
                r_apt_fail <= 1'b1;
            end
        end
    end

    // Repetition-count state; tracks every arrival, even dropped or failed ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_valid <= 1'b0;
            r_prev       <= '0;
            r_rep        <= '0;
        end else if (clear) begin
            r_prev_valid <= 1'b0;
            r_rep        <= '0;
        end else if (w_arrival) begin
            r_prev_valid <= 1'b1;
            r_prev       <= in_data;
            r_rep        <= w_rep_next;
        end
    end

    // Adaptive-proportion window: accumulate ones and restart after the last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_win <= '0;
        end else if (clear) begin
            r_acc <= '0;
            r_win <= '0;
        end else if (w_arrival) begin
            if (w_win_last) begin
                r_acc <= '0;
                r_win <= '0;
            end else begin
                r_acc <= w_apt_total;
                r_win <= r_win + 1'b1;
            end
        end
    end

    // Holds the word request low while reset is asserted and for the first
    // cycle after release, so the core is never asked for data out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    trng_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_wdata (in_data),
        .o_rdata (w_rdata),
        .o_valid (w_valid),
        .o_level (w_level)
    );

    assign out_data  = w_rdata;
    assign out_valid = w_valid;
    assign level     = w_level;
    assign overflow  = r_overflow;
    assign rct_fail  = r_rct_fail;
    assign apt_fail  = r_apt_fail;
    assign in_req    = r_run & en & ~w_fail & (w_level < LW'(DEPTH));
    assign irq       = r_overflow | w_fail |
                       ((irq_thresh != '0) & (w_level >= irq_thresh));

endmodule

// File: tb/tb_trng_health_fifo.sv
// Self-checking bench for trng_health_fifo: a table of directed vectors,
// hand-written health-test and reset sequences, then randomized traffic
// compared against a queue-based reference model.
module tb_trng_health_fifo;

   localparam int D = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        clear;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_req;
   logic        out_pop;
   logic [31:0] out_data;
   logic        out_valid;
   logic [2:0]  level;
   logic [2:0]  irq_thresh;
   logic        overflow;
   logic        rct_fail;
   logic        apt_fail;
   logic        irq;

   int checks = 0;
   int errors = 0;

   trng_health_fifo dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .clear      (clear),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_req     (in_req),
      .out_pop    (out_pop),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .level      (level),
      .irq_thresh (irq_thresh),
      .overflow   (overflow),
      .rct_fail   (rct_fail),
      .apt_fail   (apt_fail),
      .irq        (irq)
   );

   // Free-running 100 MHz clock
   always #5 clk = ~clk;

   // Reference model state: accepted words in order, sticky flags,
   // last word seen with its run length, and the running window tally.
   logic [31:0] mq[$];
   bit          mOv, mRct, mApt, mPv;
   logic [31:0] mPrev;
   int          mRep, mSum, mCnt;

   function automatic void modelReset();
      mq.delete();
      mOv = 0; mRct = 0; mApt = 0; mPv = 0;
      mPrev = '0; mRep = 0; mSum = 0; mCnt = 0;
   endfunction

   function automatic void modelStep(bit e, bit c, bit v, logic [31:0] d, bit p);
      bit arr, failed, trip, doPush, doPop;
      if (c) begin
         modelReset();
         return;
      end
      arr    = v && e;
      failed = mRct || mApt;
      trip   = 0;
      doPush = arr && !failed && (mq.size() < D || p);
      doPop  = p && mq.size() > 0;
      if (arr) begin
         if (!failed && mq.size() == D && !p) mOv = 1;
         if (mPv && d == mPrev) begin
            if (mRep < 3) mRep++;
         end else begin
            mRep = 1;
         end
         mPrev = d;
         mPv   = 1;
         if (mRep == 3) begin
            mRct = 1;
            trip = 1;
         end
         mSum += $countones(d);
         mCnt++;
         if (mCnt == 16) begin
            if (mSum < 200 || mSum > 312) begin
               mApt = 1;
               trip = 1;
            end
            mSum = 0;
            mCnt = 0;
         end
      end
      if (trip) begin
         mq.delete();
      end else begin
         if (doPop) void'(mq.pop_front());
         if (doPush) mq.push_back(d);
      end
   endfunction

   // One clock of stimulus: drive at negedge, step the model at the edge,
   // return at the next negedge with the one-cycle pulses dropped.
   task automatic applyStimulus(input bit e, input bit c, input bit v,
                                input logic [31:0] d, input bit p);
      en       = e;
      clear    = c;
      in_valid = v;
      in_data  = d;
      out_pop  = p;
      @(posedge clk);
      modelStep(e, c, v, d, p);
      @(negedge clk);
      clear    = 1'b0;
      in_valid = 1'b0;
      out_pop  = 1'b0;
   endtask

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Compare every output against the reference model
   task automatic checkOutput(input string tag);
      int  sz;
      bit  expIrq;
      sz     = mq.size();
      expIrq = mOv || mRct || mApt || (irq_thresh != 0 && sz >= int'(irq_thresh));
      checkVal({tag, ".level"}, 32'(level), 32'(sz));
      checkVal({tag, ".out_valid"}, 32'(out_valid), 32'(sz > 0));
      if (sz > 0) checkVal({tag, ".out_data"}, out_data, mq[0]);
      checkVal({tag, ".in_req"}, 32'(in_req), 32'(en && !(mRct || mApt) && sz < D));
      checkVal({tag, ".overflow"}, 32'(overflow), 32'(mOv));
      checkVal({tag, ".rct_fail"}, 32'(rct_fail), 32'(mRct));
      checkVal({tag, ".apt_fail"}, 32'(apt_fail), 32'(mApt));
      checkVal({tag, ".irq"}, 32'(irq), 32'(expIrq));
   endtask

   typedef struct {
      bit          clr;
      bit          v;
      logic [31:0] d;
      bit          p;
      int          lvl;
      bit          vld;
      logic [31:0] head;
      bit          req;
      bit          ov;
      bit          irqE;
   } vec_t;

   vec_t tbl[$];

   function automatic void addVec(bit clr, bit v, logic [31:0] d, bit p, int lvl,
                                  bit vld, logic [31:0] head, bit req, bit ov, bit irqE);
      vec_t r;
      r.clr = clr; r.v = v; r.d = d; r.p = p; r.lvl = lvl;
      r.vld = vld; r.head = head; r.req = req; r.ov = ov; r.irqE = irqE;
      tbl.push_back(r);
   endfunction

   // Watchdog so the run always ends even if the stimulus stalls
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   // Main test sequence
   initial begin
      logic [31:0] lastD;
      logic [31:0] rd;
      int          r;

      rst_n = 1'b0; en = 1'b1; clear = 1'b0; in_valid = 1'b0;
      in_data = '0; out_pop = 1'b0; irq_thresh = 3'd4;
      modelReset();
      #12;
      checkVal("rst.level", 32'(level), 0);
      checkVal("rst.out_valid", 32'(out_valid), 0);
      checkVal("rst.in_req", 32'(in_req), 0);
      checkVal("rst.irq", 32'(irq), 0);
      checkVal("rst.flags", {29'd0, overflow, rct_fail, apt_fail}, 0);
      checkVal("rst.out_data", out_data, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Fill/drain order, threshold irq, overflow drop and push-while-full-pop
      addVec(0, 1, 32'h1,  0, 1, 1, 32'h1,  1, 0, 0);
      addVec(0, 1, 32'h2,  0, 2, 1, 32'h1,  1, 0, 0);
      addVec(0, 1, 32'h3,  0, 3, 1, 32'h1,  1, 0, 0);
      addVec(0, 1, 32'h4,  0, 4, 1, 32'h1,  0, 0, 1);
      addVec(0, 0, 32'h0,  1, 3, 1, 32'h2,  1, 0, 0);
      addVec(0, 0, 32'h0,  1, 2, 1, 32'h3,  1, 0, 0);
      addVec(0, 0, 32'h0,  1, 1, 1, 32'h4,  1, 0, 0);
      addVec(0, 0, 32'h0,  1, 0, 0, 32'h0,  1, 0, 0);
      addVec(1, 0, 32'h0,  0, 0, 0, 32'h0,  1, 0, 0);
      addVec(0, 1, 32'h11, 0, 1, 1, 32'h11, 1, 0, 0);
      addVec(0, 1, 32'h12, 0, 2, 1, 32'h11, 1, 0, 0);
      addVec(0, 1, 32'h13, 0, 3, 1, 32'h11, 1, 0, 0);
      addVec(0, 1, 32'h14, 0, 4, 1, 32'h11, 0, 0, 1);
      addVec(0, 1, 32'h5,  0, 4, 1, 32'h11, 0, 1, 1);
      addVec(0, 1, 32'h5,  1, 4, 1, 32'h12, 0, 1, 1);
      addVec(0, 0, 32'h0,  1, 3, 1, 32'h13, 1, 1, 1);
      addVec(0, 0, 32'h0,  1, 2, 1, 32'h14, 1, 1, 1);
      addVec(0, 0, 32'h0,  1, 1, 1, 32'h5,  1, 1, 1);
      addVec(0, 0, 32'h0,  1, 0, 0, 32'h0,  1, 1, 1);

      for (int i = 0; i < tbl.size(); i++) begin
         applyStimulus(1, tbl[i].clr, tbl[i].v, tbl[i].d, tbl[i].p);
         checkVal($sformatf("vec%0d.level", i), 32'(level), 32'(tbl[i].lvl));
         checkVal($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(tbl[i].vld));
         if (tbl[i].vld) checkVal($sformatf("vec%0d.out_data", i), out_data, tbl[i].head);
         checkVal($sformatf("vec%0d.in_req", i), 32'(in_req), 32'(tbl[i].req));
         checkVal($sformatf("vec%0d.overflow", i), 32'(overflow), 32'(tbl[i].ov));
         checkVal($sformatf("vec%0d.irq", i), 32'(irq), 32'(tbl[i].irqE));
      end

      // Repetition count trips on the third identical word and flushes
      applyStimulus(1, 1, 0, 0, 0);
      applyStimulus(1, 0, 1, 32'hDEADBEEF, 0);
      applyStimulus(1, 0, 1, 32'hDEADBEEF, 0);
      checkVal("rct2.level", 32'(level), 2);
      checkVal("rct2.rct_fail", 32'(rct_fail), 0);
      applyStimulus(1, 0, 1, 32'hDEADBEEF, 0);
      checkVal("rct3.rct_fail", 32'(rct_fail), 1);
      checkVal("rct3.level", 32'(level), 0);
      checkVal("rct3.in_req", 32'(in_req), 0);
      checkVal("rct3.irq", 32'(irq), 1);
      checkOutput("rct3");
      applyStimulus(1, 1, 0, 0, 0);
      checkVal("rctclr.flags", {29'd0, overflow, rct_fail, apt_fail}, 0);
      checkVal("rctclr.in_req", 32'(in_req), 1);
      checkVal("rctclr.irq", 32'(irq), 0);

      // Balanced window passes, heavily biased window fails on its last word
      for (int i = 0; i < 16; i++) applyStimulus(1, 0, 1, 32'h0000FFFF, 0);
      checkVal("apt256.apt_fail", 32'(apt_fail), 0);
      checkOutput("apt256");
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1, 0, 1, (i % 2 == 0) ? 32'hFFFFFFFF : 32'hFFFFFFFE, 0);
         if (i == 14) checkVal("apt504.w15.apt_fail", 32'(apt_fail), 0);
      end
      checkVal("apt504.apt_fail", 32'(apt_fail), 1);
      checkOutput("apt504");

      // Arrival coinciding with clear is dropped and not counted by the APT
      applyStimulus(1, 1, 0, 0, 0);
      applyStimulus(1, 1, 1, 32'h0000ABCD, 0);
      checkVal("clrarr.level", 32'(level), 0);
      checkVal("clrarr.out_valid", 32'(out_valid), 0);
      for (int i = 0; i < 15; i++) applyStimulus(1, 0, 1, 32'h1 << i, 0);
      checkVal("clrarr.w15.apt_fail", 32'(apt_fail), 0);
      applyStimulus(1, 0, 1, 32'h8000, 0);
      checkVal("clrarr.w16.apt_fail", 32'(apt_fail), 1);
      checkOutput("clrarr");

      // Asynchronous reset mid-burst clears outputs before the next edge
      applyStimulus(1, 1, 0, 0, 0);
      applyStimulus(1, 0, 1, 32'hA1, 0);
      applyStimulus(1, 0, 1, 32'hA2, 0);
      applyStimulus(1, 0, 1, 32'hA3, 0);
      checkVal("arst.pre.level", 32'(level), 3);
      in_valid = 1'b1;
      in_data  = 32'hA4;
      #3;
      rst_n = 1'b0;
      #1;
      checkVal("arst.level", 32'(level), 0);
      checkVal("arst.out_valid", 32'(out_valid), 0);
      checkVal("arst.in_req", 32'(in_req), 0);
      checkVal("arst.irq", 32'(irq), 0);
      checkVal("arst.flags", {29'd0, overflow, rct_fail, apt_fail}, 0);
      checkVal("arst.out_data", out_data, 0);
      in_valid = 1'b0;
      modelReset();
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized traffic against the reference model
      lastD = 32'h0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc % 64 == 0) irq_thresh = 3'($urandom_range(0, 4));
         r = $urandom_range(0, 9);
         if (r < 2)       rd = lastD;
         else if (r == 2) rd = 32'hFFFFFFFF;
         else if (r == 3) rd = 32'h0;
         else             rd = $urandom;
         lastD = rd;
         applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0,
                       1'($urandom_range(0, 1)), rd, $urandom_range(0, 2) == 0);
         checkOutput($sformatf("rnd%0d", cyc));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/trng_health_fifo.md
Name: trng_health_fifo

Overview:
- Sits directly downstream of the dual TRNG core inside the TRNG peripheral.
- Consumes raw 32-bit random words.
- Runs two online health tests on the raw stream:
  - repetition-count test (RCT)
  - adaptive-proportion test (APT), bit-level over a word window.
- Buffers accepted words in a small FIFO for the register interface, and raises an interrupt on fill threshold, overflow or health failure.

Parameters:
- DEPTH, 4: FIFO depth in words. Must be a power of 2, ≥2.
- RCT_CUTOFF, 3: number of identical consecutive words that trips the RCT.
- APT_WORDS, 16: APT window length in words (512 bits).
- APT_LO, 200: minimum count of ones per window. Fewer trips the APT.
- APT_HI, 312: maximum count of ones per window. More trips the APT.

Ports:
- clk, input, 1: project clock.
- rst_n, input, 1: asynchronous active-low reset.
- en, input, 1: block enable.
- clear, input, 1: synchronous one-cycle pulse. Flushes the FIFO and clears all flags and test state.
- in_valid, input, 1: one-cycle strobe; in_data holds a new raw word.
- in_data, input, 32: raw random word.
- in_req, output, 1: request to the TRNG core for the next word (drives its read input).
- out_pop, input, 1: consumer pops the head word.
- out_data, output, 32: FIFO head word. Valid only when out_valid=1.
- out_valid, output, 1: FIFO not empty.
- level, output, $clog2(DEPTH)+1: FIFO occupancy.
- irq_thresh, input, $clog2(DEPTH)+1: occupancy interrupt threshold. 0 disables it.
- overflow, output, 1: sticky; a word arrived while the FIFO was full.
- rct_fail, output, 1: sticky RCT failure.
- apt_fail, output, 1: sticky APT failure.
- irq, output, 1: interrupt request.

Behaviour:

Clock and reset:
- Single clock domain on clk.
- rst_n is asynchronous, active-low; all state clears immediately.
- Reset values:
  - level=0, out_valid=0, in_req=0, overflow=0, rct_fail=0, apt_fail=0, irq=0.
  - out_data=0, with memory and pointers zeroed.
  - RCT/APT counters and prev_valid=0.

Signals:
- fail = rct_fail | apt_fail.
- in_req = en & !fail & (level < DEPTH). Combinational from registers.
- arrival = in_valid & en & !clear.

Push/pop:
- push = arrival & !fail & (level<DEPTH | out_pop).
- pop = out_pop & out_valid. A pop while empty is ignored.
- Simultaneous push+pop: level unchanged; both pointers advance. This is legal when full.
- Push writes at the write pointer on the clock edge. Visibility:
  - out_valid rises one cycle after the push edge.
  - out_data = mem[rd_ptr], combinational from registers.
- Pointers wrap modulo DEPTH. level has one extra bit to distinguish full from empty.

Overflow:
- arrival & !fail & level==DEPTH & !out_pop → word dropped, overflow<=1.
- Health tests still see the dropped word.

RCT (on every arrival, including while fail=1):
- If !prev_valid: prev<=in_data, rep<=1, prev_valid<=1.
- Else if in_data==prev: rep<=rep+1. Saturates at RCT_CUTOFF.
- Else: prev<=in_data, rep<=1.
- When the new rep value == RCT_CUTOFF: rct_fail<=1 in the same edge.

APT (on every arrival):
- acc <= acc + popcount(in_data); acc width 10 bits.
- win increments 0..APT_WORDS-1.
- On the arrival with win==APT_WORDS-1:
  - total = acc + popcount(in_data).
  - If total<APT_LO or total>APT_HI: apt_fail<=1.
  - acc<=0, win<=0.

Failure:
- On the edge where rct_fail or apt_fail first sets, the FIFO is flushed (level<=0, pointers<=0).
- A push on that same edge is discarded.
- While fail=1: no pushes; pops of an empty FIFO are ignored.

clear:
- Highest priority over push, pop and arrival in the same cycle.
- Resets the FIFO, overflow, rct_fail, apt_fail, prev_valid, rep, acc and win.

en=0:
- in_req=0; arrivals are ignored.
- Test state is held.
- FIFO contents remain poppable.

irq:
- Combinational: overflow | rct_fail | apt_fail | (irq_thresh!=0 & level>=irq_thresh).

Decomposition:
- Package trng_pkg:
  - FIFO_DEPTH default.
  - RCT/APT default constants.
  - Typedef for 32-bit word.
  - popcount32 function.
- Sub-module trng_fifo holds the FIFO storage, pointers and level.
  - Inputs: push, pop, flush.
- Health logic, flags and irq stay in the top.

Test Plan:
1. Push 0x1, 0x2, 0x3, 0x4 with irq_thresh=4 →
   - level=4, in_req=0, irq=1.
   - Pops return 0x1, 0x2, 0x3, 0x4 in order; level ends 0.
2. Fill to 4, then in_valid with 0x5 and no pop → overflow=1, irq=1, level=4, 0x5 absent. Repeat with out_pop=1 → 0x5 accepted, level stays 4.
3. Three arrivals of 0xDEADBEEF →
   - rct_fail=1 on the third arrival edge.
   - FIFO flushed (level=0); in_req=0.
   - clear pulse → all flags 0, in_req=1.
4. 16 arrivals of 0x0000FFFF (total 256) → apt_fail=0. Then 16 arrivals alternating 0xFFFFFFFF / 0xFFFFFFFE (total 504) → apt_fail=1 on the 16th of that window.
5. Assert rst_n=0 asynchronously mid-burst with level=3 → all outputs 0 before the next clk edge.
6. clear and in_valid in the same cycle → word not stored, level=0, APT win=0.
